// File: rtl/calc_core.sv
`default_nettype none
// ============================================================================
//  Module   : calc_core
//  Purpose  : Two-operand decimal keypad calculator core. Collects up to two
//             BCD digits per operand, latches an operator, then runs a fixed
//             8-cycle calculation (sequential shift-add multiply, plus sum and
//             absolute difference) and presents registered binary results
//             with a one-hot result select for the BCD display stage.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1   clock, rising edge
//    rst          in   1   synchronous active-high reset
//    digit_valid  in   1   strobe: digit is a keypad digit
//    digit        in   4   BCD digit (10-15 ignored)
//    op_valid     in   1   strobe: op is an operator
//    op           in   2   00 add, 01 subtract, 10 multiply, 11 reserved
//    eq           in   1   strobe: start calculation
//    clr          in   1   strobe: clear everything
//    add_trig     out  14  A+B
//    sub_trig     out  14  |A-B|
//    mul_trig     out  14  A*B
//    sum_enable   out  1   result select: add
//    minus_enable out  1   result select: subtract
//    multiply     out  1   result select: multiply
//    neg          out  1   A<B (valid with minus_enable)
//    busy         out  1   calculation in progress
// ============================================================================
module calc_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        op_valid,
  input  logic [1:0]  op,
  input  logic        eq,
  input  logic        clr,
  output logic [13:0] add_trig,
  output logic [13:0] sub_trig,
  output logic [13:0] mul_trig,
  output logic        sum_enable,
  output logic        minus_enable,
  output logic        multiply,
  output logic        neg,
  output logic        busy
);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    CALC    = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;
  localparam logic [2:0] LAST_STEP = 3'd7;

  state_t      state;
  logic [6:0]  a;
  logic [6:0]  b;
  logic [1:0]  cnt_a;
  logic [1:0]  cnt_b;
  logic [1:0]  op_q;
  logic [13:0] acc;
  logic [13:0] mcand;
  logic [6:0]  mplier;
  logic [2:0]  step;

  logic        digit_ok;
  logic        op_ok;
  logic [13:0] a_ext;
  logic [13:0] b_ext;

  assign digit_ok = digit_valid && (digit <= 4'd9);
  assign op_ok    = op_valid && (op != OP_RSV);
  assign a_ext    = {7'd0, a};
  assign b_ext    = {7'd0, b};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state        <= ENTER_A;
      a            <= '0;
      b            <= '0;
      cnt_a        <= '0;
      cnt_b        <= '0;
      op_q         <= '0;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      step         <= '0;
      add_trig     <= '0;
      sub_trig     <= '0;
      mul_trig     <= '0;
      sum_enable   <= 1'b0;
      minus_enable <= 1'b0;
      multiply     <= 1'b0;
      neg          <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        ENTER_A: begin
          // eq is not applicable here, so op_valid is the top candidate.
          if (op_ok) begin
            op_q  <= op;
            b     <= '0;
            cnt_b <= '0;
            state <= ENTER_B;
          end else if (digit_ok && (cnt_a < 2'd2)) begin
            // At most one digit is held here, so a*10+digit stays <= 99.
            a     <= a * 7'd10 + {3'd0, digit};
            cnt_a <= cnt_a + 2'd1;
          end
        end
        ENTER_B: begin
          if (eq) begin
            acc    <= '0;
            mcand  <= a_ext;
            mplier <= b;
            step   <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end else if (op_ok) begin
            op_q <= op;
          end else if (digit_ok && (cnt_b < 2'd2)) begin
            b     <= b * 7'd10 + {3'd0, digit};
            cnt_b <= cnt_b + 2'd1;
          end
        end
        CALC: begin
          if (step == LAST_STEP) begin
            // Seven shift-add steps are complete; publish everything at once.
            add_trig     <= a_ext + b_ext;
            sub_trig     <= (a >= b) ? (a_ext - b_ext) : (b_ext - a_ext);
            neg          <= (a < b);
            mul_trig     <= acc;
            sum_enable   <= (op_q == OP_ADD);
            minus_enable <= (op_q == OP_SUB);
            multiply     <= (op_q == OP_MUL);
            busy         <= 1'b0;
            state        <= DONE;
          end else begin
            if (mplier[0]) begin
              acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            step   <= step + 3'd1;
          end
        end
        DONE: begin
          // A fresh digit starts a new entry; results stay visible.
          if (digit_ok) begin
            sum_enable   <= 1'b0;
            minus_enable <= 1'b0;
            multiply     <= 1'b0;
            a            <= {3'd0, digit};
            cnt_a        <= 2'd1;
            state        <= ENTER_A;
          end
        end
        default: state <= ENTER_A;
      endcase
    end
  end

endmodule
`default_nettype wire
